// File: rtl/text_glyph_pipeline.sv
// text_glyph_pipeline: text-mode pixel stage between the register/VRAM block and
// the TMDS encoder. Looks up the glyph row in a synchronous font ROM and emits
// registered 4-bit RGB with hsync/vsync/vde delayed to stay aligned (2 cycles).
// Optional blinking underline cursor is enabled by defining CURSOR_EN.
module text_glyph_pipeline #(
  parameter int unsigned FONT_ADDR_W  = 11,
  parameter logic        SYNC_RST_LVL = 1'b1,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                   pixel_clk,
  input  logic                   reset,
  input  logic [9:0]             drawX,
  input  logic [9:0]             drawY,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   vde,
  input  logic [6:0]             pix_code,
  input  logic                   invert,
  input  logic [3:0]             fg [3],
  input  logic [3:0]             bg [3],
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_data,
  input  logic [6:0]             cursor_col,
  input  logic [4:0]             cursor_row,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   vde_out
);

  // S0: ROM address straight from the current cell code and glyph row
  assign font_addr = FONT_ADDR_W'({pix_code, drawY[3:0]});

  logic cursor_hit;
  logic unused_row_msb;
  assign unused_row_msb = drawY[9];

`ifdef CURSOR_EN
  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CntW-1:0] frame_cnt;
  logic            blink_phase;
  logic            vsync_prev;
  logic            vsync_fall;

  assign vsync_fall = vsync_prev & ~vsync;

  // Frame counter on vsync falling edges; toggles the blink phase at wrap.
  // vsync_prev follows the input during reset so no edge is seen on release.
  always_ff @(posedge pixel_clk) begin
    vsync_prev <= vsync;
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (vsync_fall) begin
      if (frame_cnt == CntW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Underline cursor occupies the bottom two glyph rows of the cursor cell
  assign cursor_hit = (drawX[9:3] == cursor_col) && (drawY[8:4] == cursor_row) &&
                      (drawY[3:0] >= 4'd14) && blink_phase;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row, drawX[9:3], drawY[8:4]};
  assign cursor_hit    = 1'b0;
`endif

  // S1 pipeline registers
  logic [2:0] xbit_s1;
  logic       invert_s1;
  logic       hit_s1;
  logic [3:0] fg_s1 [3];
  logic [3:0] bg_s1 [3];
  logic       hsync_s1;
  logic       vsync_s1;
  logic       vde_s1;

  // S1: capture per-pixel attributes while the ROM read is in flight
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      xbit_s1   <= '0;
      invert_s1 <= 1'b0;
      hit_s1    <= 1'b0;
      hsync_s1  <= SYNC_RST_LVL;
      vsync_s1  <= SYNC_RST_LVL;
      vde_s1    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        fg_s1[i] <= '0;
        bg_s1[i] <= '0;
      end
    end else begin
      xbit_s1   <= drawX[2:0];
      invert_s1 <= invert;
      hit_s1    <= cursor_hit;
      hsync_s1  <= hsync;
      vsync_s1  <= vsync;
      vde_s1    <= vde;
      for (int i = 0; i < 3; i++) begin
        fg_s1[i] <= fg[i];
        bg_s1[i] <= bg[i];
      end
    end
  end

  logic       pix_on;
  logic [3:0] rgb_d [3];

  // Select glyph bit (bit 7 = leftmost) and pick fg/bg; blank outside active video
  always_comb begin
    pix_on = font_data[3'd7 - xbit_s1] ^ invert_s1 ^ hit_s1;
    for (int i = 0; i < 3; i++) begin
      rgb_d[i] = '0;
      if (vde_s1) rgb_d[i] = pix_on ? fg_s1[i] : bg_s1[i];
    end
  end

  // S2: registered outputs
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync_out <= SYNC_RST_LVL;
      vsync_out <= SYNC_RST_LVL;
      vde_out   <= 1'b0;
    end else begin
      red       <= rgb_d[0];
      green     <= rgb_d[1];
      blue      <= rgb_d[2];
      hsync_out <= hsync_s1;
      vsync_out <= vsync_s1;
      vde_out   <= vde_s1;
    end
  end

endmodule

// File: tb/tb_text_glyph_pipeline.sv
// Scoreboard bench for text_glyph_pipeline: expected pixels are pushed when
// inputs are driven and compared two cycles later. Cursor checks follow CURSOR_EN.
module tb_text_glyph_pipeline;

`ifdef CURSOR_EN
  localparam bit CursorEn = 1'b1;
`else
  localparam bit CursorEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY;
  logic        hsync, vsync, vde;
  logic [6:0]  pix_code;
  logic        invert;
  logic [3:0]  fg [3];
  logic [3:0]  bg [3];
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [3:0]  red, green, blue;
  logic        hsync_out, vsync_out, vde_out;

  text_glyph_pipeline #(
    .FONT_ADDR_W (11),
    .SYNC_RST_LVL(1'b1),
    .BLINK_FRAMES(2)
  ) dut (
    .pixel_clk (clk),
    .reset     (reset),
    .drawX     (drawX),
    .drawY     (drawY),
    .hsync     (hsync),
    .vsync     (vsync),
    .vde       (vde),
    .pix_code  (pix_code),
    .invert    (invert),
    .fg        (fg),
    .bg        (bg),
    .font_addr (font_addr),
    .font_data (font_data),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .vde_out   (vde_out)
  );

  always #5 clk = ~clk;

  // Synchronous font ROM model
  logic [7:0] rom [2048];
  always @(posedge clk) font_data <= rom[font_addr];

  typedef struct packed {
    logic        rst;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Staged stimulus, applied at the next falling edge by step()
  logic       t_rst, t_hs, t_vs, t_de, t_inv;
  logic [9:0] t_x, t_y;
  logic [6:0] t_code;
  logic [3:0] t_fg [3];
  logic [3:0] t_bg [3];
  logic       blink_tb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    exp_t       p, e;
    logic [7:0] rowb;
    logic       hit, on;
    @(negedge clk);
    if (q.size() >= 2) begin
      p = q.pop_front();
      if (p.rst || q[0].rst) begin
        p.rgb = '0; p.hs = 1'b1; p.vs = 1'b1; p.de = 1'b0;
      end
      check_eq("rgb", {red, green, blue}, p.rgb);
      check_eq("hsync_out", hsync_out, p.hs);
      check_eq("vsync_out", vsync_out, p.vs);
      check_eq("vde_out", vde_out, p.de);
    end
    reset = t_rst; drawX = t_x; drawY = t_y; hsync = t_hs; vsync = t_vs; vde = t_de;
    pix_code = t_code; invert = t_inv;
    for (int i = 0; i < 3; i++) begin
      fg[i] = t_fg[i];
      bg[i] = t_bg[i];
    end
    hit = CursorEn && (t_x[9:3] == cursor_col) && (t_y[8:4] == cursor_row) &&
          (t_y[3:0] >= 4'd14) && blink_tb;
    rowb = rom[{t_code, t_y[3:0]}];
    on   = rowb[7 - t_x[2:0]] ^ t_inv ^ hit;
    e.rst = t_rst;
    e.rgb = t_de ? (on ? {t_fg[0], t_fg[1], t_fg[2]} : {t_bg[0], t_bg[1], t_bg[2]}) : 12'h0;
    e.hs  = t_hs;
    e.vs  = t_vs;
    e.de  = t_de;
    q.push_back(e);
    #1 check_eq("font_addr", font_addr, {t_code, t_y[3:0]});
  endtask

  task automatic set_col(input logic [11:0] f, input logic [11:0] b);
    t_fg[0] = f[11:8]; t_fg[1] = f[7:4]; t_fg[2] = f[3:0];
    t_bg[0] = b[11:8]; t_bg[1] = b[7:4]; t_bg[2] = b[3:0];
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h415] = 8'h80;
    for (int r = 0; r < 16; r++) begin
      rom[{7'h7F, 4'(r)}] = 8'hFF;
      rom[{7'h2A, 4'(r)}] = 8'hAA;
      rom[{7'h55, 4'(r)}] = 8'h55;
    end
    cursor_col = 7'd3; cursor_row = 5'd2; blink_tb = 1'b1;
    t_inv = 1'b0; t_code = 7'h41; t_x = '0; t_y = '0;
    set_col(12'hF00, 12'h00F);

    // Reset held 3 cycles with vde=1 and syncs low
    t_rst = 1'b1; t_de = 1'b1; t_hs = 1'b0; t_vs = 1'b0;
    repeat (3) step();
    check_eq("rst_rgb", {red, green, blue}, 12'h0);

    // Address and latency: 'A' row 5, ROM 0x80
    t_rst = 1'b0; t_hs = 1'b1; t_vs = 1'b1; t_code = 7'h41; t_y = 10'd5;
    t_x = 10'd0; step();
    check_eq("font_addr_415", font_addr, 11'h415);
    t_x = 10'd1; step();
    for (int x = 2; x < 8; x++) begin t_x = 10'(x); step(); end

    // Invert over a solid glyph: whole cell shows bg
    t_code = 7'h7F; t_inv = 1'b1; set_col(12'hABC, 12'h123);
    for (int x = 8; x < 16; x++) begin t_x = 10'(x); step(); end
    t_inv = 1'b0;

    // Blanking plus a 96-cycle hsync pulse
    t_de = 1'b0;
    for (int i = 0; i < 110; i++) begin
      t_x = 10'(i);
      t_hs = (i >= 4 && i < 100) ? 1'b0 : 1'b1;
      step();
    end

    // Back-to-back checkerboard line
    t_de = 1'b1; t_y = 10'd3; set_col(12'hFFF, 12'h000);
    for (int x = 0; x < 640; x++) begin
      t_x = 10'(x);
      t_code = ((x >> 3) & 1) ? 7'h55 : 7'h2A;
      step();
    end

    // Single-cycle reset mid-line
    for (int x = 0; x < 16; x++) begin
      t_x = 10'(x);
      t_rst = (x == 6);
      step();
    end
    t_rst = 1'b0;

    // Cursor blink across six frames (only inverts with CURSOR_EN)
    t_code = 7'h41; set_col(12'h7E1, 12'h248);
    for (int f = 0; f < 6; f++) begin
      blink_tb = ((f / 2) % 2) == 0;
      t_de = 1'b1;
      for (int y = 45; y < 48; y++)
        for (int x = 16; x < 40; x++) begin
          t_x = 10'(x); t_y = 10'(y); step();
        end
      t_de = 1'b0; t_y = '0; t_x = '0;
      repeat (3) step();
      t_vs = 1'b0; repeat (2) step();
      t_vs = 1'b1; repeat (2) step();
    end

    // Drain the pipeline
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_glyph_pipeline.md
Name: text_glyph_pipeline

Overview:
Pixel-domain stage directly downstream of the text-mode register/VRAM block. Takes that block's per-pixel character code, invert bit and fg/bg palette (combinational on drawX/drawY), fetches the glyph row from a synchronous font ROM, and outputs registered 4-bit RGB. It also delays hsync/vsync/vde so they stay aligned with the RGB output. Its outputs feed the HDMI/TMDS encoder.

Parameters:
FONT_ADDR_W, 11, font ROM address width; address is {pix_code[6:0], drawY[3:0]}.
SYNC_RST_LVL, 1'b1, reset and flush value of hsync_out/vsync_out (idle level of the active-low syncs).
BLINK_FRAMES, 30, frames per cursor blink phase; used only with CURSOR_EN.

Ports:
pixel_clk  in  1  pixel clock; the only clock.
reset  in  1  one clock; reset is synchronous and active-high.
drawX  in  10  current pixel column.
drawY  in  10  current pixel row.
hsync  in  1  horizontal sync, aligned with drawX/drawY.
vsync  in  1  vertical sync, aligned with drawX/drawY.
vde  in  1  active-video enable, aligned with drawX/drawY.
pix_code  in  7  character code for the current cell.
invert  in  1  cell invert bit.
fg  in  3x4  foreground {R,G,B}; element 0 is R.
bg  in  3x4  background {R,G,B}; element 0 is R.
font_addr  out  FONT_ADDR_W  combinational {pix_code, drawY[3:0]}.
font_data  in  8  ROM row data, valid 1 cycle after font_addr; bit 7 is the leftmost pixel.
cursor_col  in  7  cursor column 0..79 (CURSOR_EN only).
cursor_row  in  5  cursor row 0..29 (CURSOR_EN only).
red  out  4  pixel red.
green  out  4  pixel green.
blue  out  4  pixel blue.
hsync_out  out  1  hsync delayed 2 cycles.
vsync_out  out  1  vsync delayed 2 cycles.
vde_out  out  1  vde delayed 2 cycles.

Behaviour:
- Reset (synchronous): red/green/blue=0, vde_out=0, hsync_out=vsync_out=SYNC_RST_LVL. All pipeline registers are cleared to the same values. Outputs keep these values until valid data has propagated through.
- S0 (input cycle): font_addr is driven combinationally from pix_code and drawY[3:0].
- S1 register: xbit=drawX[2:0], invert, fg, bg, hsync, vsync, vde. font_data is valid during S1.
- S2 register (outputs):
  - on = font_data[7-xbit] XOR invert_s1 (XOR cursor_hit when CURSOR_EN).
  - RGB = on ? fg_s1 : bg_s1.
  - When vde_s1=0, RGB=0 regardless of glyph.
- Latency: exactly 2 pixel_clk cycles from drawX/drawY/sync in to RGB/sync out. There is no backpressure and no stall. A new pixel is accepted every cycle.
- Sync and vde pass through unmodified (same polarity), delayed 2 cycles.
- Reset mid-line: on the next edge the pipeline is cleared to reset values and resumes 2 cycles after reset deasserts. There is no partial-pixel carryover.
- drawX/drawY outside 640x480 are not special-cased; vde governs blanking.

Optional Feature:
Macro CURSOR_EN.
- Enabled:
  - A vsync falling-edge detector (a registered previous vsync) drives a frame counter that counts 0..BLINK_FRAMES-1. At wrap, the counter returns to 0 and blink_phase toggles.
  - Reset: counter=0, blink_phase=1.
  - cursor_hit is computed in S0 and registered into S1:
    - drawX[9:3]==cursor_col
    - drawY[8:4]==cursor_row
    - drawY[3:0]>=14
    - blink_phase=1
  - A hit inverts `on` (underline cursor). A vsync edge coincident with reset is ignored.
- Disabled: the cursor ports are present but ignored; there is no counter logic and cursor_hit is 0.

Test Plan:
- Reset held 3 cycles, with vde=1, hsync=0, vsync=0 in -> RGB=0, vde_out=0, hsync_out=vsync_out=1 throughout. The first non-reset input appears at the outputs 2 cycles after reset deasserts.
- Latency/addr:
  - Inputs: pix_code=0x41, drawY=5 -> font_addr=0x415 in the same cycle.
  - ROM returns 0x80; drawX=0, fg={F,0,0}, bg={0,0,F}, vde=1.
  - Expected: 2 cycles later, RGB={F,0,0}.
  - With drawX=1, expected RGB={0,0,F}.
- Invert: font_data=0xFF, invert=1, fg={A,B,C}, bg={1,2,3} -> all 8 pixels of the cell output {1,2,3}.
- Blanking and sync delay: vde=0 with font_data=0xFF -> RGB=0. An hsync pulse 0 for 96 cycles appears on hsync_out shifted exactly 2 cycles, with identical width.
- Back-to-back stream: drawX sweeping 0..639 with alternating font_data 0xAA/0x55 per cell -> output is an exact checkerboard matching a reference model with 2-cycle offset, with no dropped pixels.
- CURSOR_EN:
  - Setup: cursor_col=3, cursor_row=2, BLINK_FRAMES=2.
  - Expected: pixels at drawX 24..31, drawY 46..47 are inverted during frames 0-1, normal during frames 2-3, and inverted again during frames 4-5.
  - Expected: drawY=45 is never inverted.
